// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES-128 key-schedule controller.
//   aes_128      : 128-bit key / round-key word
//   aes_byte     : 8-bit GF(2^8) element (round constant)
//   NUM_RNDS_DEF : default number of expansion rounds for AES-128
//   aes_state_e  : controller FSM states
//   xtime()      : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_128;
  typedef logic [7:0]   aes_byte;

  localparam int NUM_RNDS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } aes_state_e;

  function automatic aes_byte xtime(input aes_byte b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// -----------------------------------------------------------------------------
// aes_rcon_gen
// Round-constant register. Loads 8'h01 at the start of an expansion, advances
// by xtime on every step, and returns to 0 on clear or reset.
// Ports:
//   clk      in  clock
//   rst_i    in  synchronous active-high reset
//   load_i   in  load the first round constant (8'h01)
//   step_i   in  advance to the next round constant
//   clear_i  in  force the register to 0
//   rcon_o   out current round constant
// -----------------------------------------------------------------------------
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    rst_i,
  input  logic    load_i,
  input  logic    step_i,
  input  logic    clear_i,
  output aes_byte rcon_o
);

  aes_byte rcon_q;

  always_ff @(posedge clk) begin
    if (rst_i || clear_i) begin
      rcon_q <= 8'h00;
    end else if (load_i) begin
      rcon_q <= 8'h01;
    end else if (step_i) begin
      rcon_q <= xtime(rcon_q);
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// Sequences an external registered AES-128 key-gen round through NUM_RNDS
// expansions and streams round keys 0..NUM_RNDS on rk_o.
// Optional macro: AES_KEY_STORE_EN adds a (NUM_RNDS+1) x 128 round-key store
// with a combinational read port (rd_idx_i / rd_key_o).
// Ports:
//   clk            in   clock
//   nrst           in   synchronous active-high reset
//   key_valid_i    in   cipher key offered on key_i
//   key_ready_o    out  key can be accepted (IDLE only)
//   key_i          in   cipher key
//   kg_key_o       out  latched cipher key to key-gen
//   kg_en_o        out  key-gen enable
//   kg_gen_key_o   out  key-gen rcon select
//   kg_next_rnd_o  out  key-gen feedback select (0 cipher key, 1 previous)
//   kg_rcon_o      out  round constant to key-gen
//   kg_key_i       in   registered round key from key-gen
//   rk_valid_o     out  rk_o / rk_idx_o valid
//   rk_idx_o       out  round index
//   rk_o           out  round key
//   busy_o         out  expansion in progress
//   done_o         out  pulse with the final round key
//   rd_idx_i       in   store read index          (AES_KEY_STORE_EN only)
//   rd_key_o       out  store read data           (AES_KEY_STORE_EN only)
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_RNDS = NUM_RNDS_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  output logic [127:0] kg_key_o,
  output logic         kg_en_o,
  output logic         kg_gen_key_o,
  output logic         kg_next_rnd_o,
  output logic [7:0]   kg_rcon_o,
  input  logic [127:0] kg_key_i,
  output logic         rk_valid_o,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_o,
  output logic         busy_o,
  output logic         done_o
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_RNDS);

  aes_state_e state_q, state_d;
  logic [3:0] cnt_q;
  aes_128     key_q;
  aes_byte    rcon;
  logic       hs;

  assign hs = (state_q == ST_IDLE) && key_valid_i;

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (key_valid_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_EXPAND;
      ST_EXPAND: if (cnt_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Counter holds the round index of the key currently on rk_o:
  // 0 in LOAD, k in EXPAND.
  always_ff @(posedge clk) begin
    if (nrst) begin
      cnt_q <= 4'd0;
    end else if ((state_q == ST_LOAD) || (state_q == ST_EXPAND)) begin
      cnt_q <= cnt_q + 4'd1;
    end else begin
      cnt_q <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      key_q <= '0;
    end else if (hs) begin
      key_q <= key_i;
    end
  end

  assign kg_key_o = key_q;

  // The rcon register runs one round ahead of rk_idx_o because the key-gen
  // result appears one cycle after it is enabled.
  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst_i   (nrst),
    .load_i  (hs),
    .step_i  (kg_en_o),
    .clear_i (state_q == ST_DONE),
    .rcon_o  (rcon)
  );

  always_comb begin
    key_ready_o   = (state_q == ST_IDLE) && !nrst;
    kg_en_o       = 1'b0;
    kg_gen_key_o  = 1'b0;
    kg_next_rnd_o = 1'b0;
    rk_valid_o    = 1'b0;
    rk_idx_o      = 4'd0;
    rk_o          = '0;
    done_o        = 1'b0;
    busy_o        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_LOAD: begin
        kg_en_o      = 1'b1;
        kg_gen_key_o = 1'b1;
        rk_valid_o   = 1'b1;
        rk_o         = key_q;
      end
      ST_EXPAND: begin
        rk_valid_o = 1'b1;
        rk_idx_o   = cnt_q;
        rk_o       = kg_key_i;
        if (cnt_q == LAST_IDX) begin
          done_o = 1'b1;
        end else begin
          kg_en_o       = 1'b1;
          kg_gen_key_o  = 1'b1;
          kg_next_rnd_o = 1'b1;
        end
      end
      default: ;
    endcase
    kg_rcon_o = kg_en_o ? rcon : 8'h00;
  end

`ifdef AES_KEY_STORE_EN
  aes_128 store_q [NUM_RNDS+1];

  // Store is deliberately unreset; a same-cycle read sees the old entry.
  always_ff @(posedge clk) begin
    if (rk_valid_o) begin
      store_q[rk_idx_o] <= rk_o;
    end
  end

  assign rd_key_o = (rd_idx_i <= LAST_IDX) ? store_q[rd_idx_i] : '0;
`endif

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         nrst;
  logic         key_valid_i;
  logic         key_ready_o;
  logic [127:0] key_i;
  logic [127:0] kg_key_o;
  logic         kg_en_o;
  logic         kg_gen_key_o;
  logic         kg_next_rnd_o;
  logic [7:0]   kg_rcon_o;
  logic [127:0] kg_key_i;
  logic         rk_valid_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_o;
  logic         busy_o;
  logic         done_o;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_key_o;
`endif

  aes_key_sched_ctrl #(.NUM_RNDS(10)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .key_valid_i   (key_valid_i),
    .key_ready_o   (key_ready_o),
    .key_i         (key_i),
    .kg_key_o      (kg_key_o),
    .kg_en_o       (kg_en_o),
    .kg_gen_key_o  (kg_gen_key_o),
    .kg_next_rnd_o (kg_next_rnd_o),
    .kg_rcon_o     (kg_rcon_o),
    .kg_key_i      (kg_key_i),
    .rk_valid_o    (rk_valid_o),
    .rk_idx_o      (rk_idx_o),
    .rk_o          (rk_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx_i      (rd_idx_i),
    .rd_key_o      (rd_key_o)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_Z = 128'h0;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C = 128'hffeeddccbbaa99887766554433221100;

  localparam logic [127:0] HAND_A [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] HAND_Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] HAND_Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [79:0]  RCON_SEQ = 80'h01020408102040801b36;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];

  logic [7:0] sbox_t [256];

  function automatic logic [7:0] bxtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) r = r ^ x;
      x = bxtime(x);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] inv;
      logic [7:0] p;
      logic [7:0] b;
      b   = i[7:0];
      inv = 8'h00;
      if (i != 0) begin
        p = 8'h01;
        repeat (254) p = gmul(p, b);
        inv = p;
      end
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] round_step(input logic [127:0] src, input logic [7:0] rc);
    logic [31:0] w3, rot, sub, t, n0, n1, n2, n3;
    w3  = src[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox_t[rot[31:24]], sbox_t[rot[23:16]], sbox_t[rot[15:8]], sbox_t[rot[7:0]]};
    t   = sub ^ {rc, 24'h0};
    n0  = src[127:96] ^ t;
    n1  = src[95:64] ^ n0;
    n2  = src[63:32] ^ n1;
    n3  = src[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ref_rk(input logic [127:0] k, input int idx);
    logic [127:0] r  = k;
    logic [7:0]   rc = 8'h01;
    for (int i = 1; i <= idx; i++) begin
      r  = round_step(r, rc);
      rc = bxtime(rc);
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_rk(input logic [127:0] k, input int idx);
    if (k == KEY_A) return HAND_A[idx];
    if (k == KEY_Z && idx == 1) return HAND_Z1;
    if (k == KEY_Z && idx == 10) return HAND_Z10;
    return ref_rk(k, idx);
  endfunction

  // Registered key-gen round, as the controller expects to drive it.
  logic [127:0] kg_q = '0;
  always @(posedge clk) begin
    if (kg_en_o)
      kg_q <= round_step(kg_next_rnd_o ? kg_q : kg_key_o, kg_gen_key_o ? kg_rcon_o : 8'h00);
  end
  assign kg_key_i = kg_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: schedule the 11 expected round keys.
  always @(negedge clk) begin
    if (key_valid_i && key_ready_o) begin
      hs_cyc.push_back(cyc);
      for (int i = 0; i <= 10; i++) begin
        exp_t e;
        e.idx  = 4'(i);
        e.rk   = exp_rk(key_i, i);
        e.done = (i == 10);
        exp_q.push_back(e);
      end
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rk_valid_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rk_unexpected: got idx=%0d rk=%h done=%b, required no output", rk_idx_o, rk_o, done_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rk_idx_o !== e.idx || rk_o !== e.rk || done_o !== e.done) begin
          miscompares++;
          $display("FAIL rk_stream: got idx=%0d rk=%h done=%b, required idx=%0d rk=%h done=%b",
                   rk_idx_o, rk_o, done_o, e.idx, e.rk, e.done);
        end
      end
    end else if (done_o) begin
      vectors++;
      miscompares++;
      $display("FAIL done_alone: got done=1 with rk_valid=0, required done=0");
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    int n = 0;
    key_i       = k;
    key_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (key_ready_o) break;
      n++;
      if (n > 100) begin
        $display("FAIL handshake_timeout: got key_ready_o=0 for 100 cycles, required 1");
        miscompares++;
        vectors++;
        break;
      end
    end
    @(posedge clk);
    #1 key_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [79:0] seq;
    int          rc_cnt;
    int          n;
    int          hs0;

    nrst        = 1'b1;
    key_valid_i = 1'b0;
    key_i       = '0;
`ifdef AES_KEY_STORE_EN
    rd_idx_i    = 4'd0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_rk_valid", 128'(rk_valid_o), 128'd0);
    check("rst_kg_key", kg_key_o, 128'd0);
    check("rst_kg_en_rcon", {119'd0, kg_en_o, kg_rcon_o}, 128'd0);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    check("rst_ready_after_release", 128'(key_ready_o), 128'd1);

    // Reference key: rcon sequence and FSM timing.
    send_key(KEY_A);
    seq    = '0;
    rc_cnt = 0;
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      if (kg_en_o) begin
        seq = {seq[71:0], kg_rcon_o};
        rc_cnt++;
      end
      if (j == 1) check("load_ctrl", {124'd0, kg_en_o, kg_gen_key_o, kg_next_rnd_o, busy_o}, 128'b1101);
      if (j == 2) check("expand_ctrl", {124'd0, kg_en_o, kg_gen_key_o, kg_next_rnd_o, busy_o}, 128'b1111);
      if (j == 12) check("done_state", {126'd0, key_ready_o, busy_o}, 128'b01);
      if (j == 13) check("idle_again", {126'd0, key_ready_o, busy_o}, 128'b10);
    end
    check("rcon_count", 128'(rc_cnt), 128'd10);
    check("rcon_seq", 128'(seq), 128'(RCON_SEQ));
    check("kg_key_latched", kg_key_o, KEY_A);

`ifdef AES_KEY_STORE_EN
    rd_idx_i = 4'd10;
    #1 check("store_idx10", rd_key_o, HAND_A[10]);
    rd_idx_i = 4'd0;
    #1 check("store_idx0", rd_key_o, KEY_A);
    rd_idx_i = 4'd15;
    #1 check("store_idx15", rd_key_o, 128'd0);
`endif

    // key_valid held through an expansion: one handshake per 13 cycles.
    hs0         = hs_cyc.size();
    key_i       = KEY_Z;
    key_valid_i = 1'b1;
    n = 0;
    while (hs_cyc.size() < hs0 + 1 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 key_i = KEY_B;
    n = 0;
    while (hs_cyc.size() < hs0 + 2 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 key_valid_i = 1'b0;
    if (hs_cyc.size() >= hs0 + 2)
      check("hs_spacing", 128'(hs_cyc[hs0+1] - hs_cyc[hs0]), 128'd13);
    else
      check("hs_count", 128'(hs_cyc.size() - hs0), 128'd2);
    drain();

    // Reset mid-expansion.
    send_key(KEY_B);
    repeat (4) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1 exp_q.delete();
    @(negedge clk);
    check("abort_outputs", {125'd0, rk_valid_o, done_o, busy_o}, 128'd0);
    @(posedge clk);
    #1 nrst = 1'b0;
    @(negedge clk);
    check("abort_ready", 128'(key_ready_o), 128'd1);
    send_key(KEY_C);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
